// File: rtl/lr_ras_pkg.sv
// Common constants and helpers for the return-address stack.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef RAS_DEPTH
`define RAS_DEPTH 8
`endif
`ifndef RAS_PTR_W
`define RAS_PTR_W 3
`endif
`ifndef RAS_IDLE
`define RAS_IDLE 1'b0
`endif
`ifndef RAS_RET
`define RAS_RET 1'b1
`endif
package lr_ras_pkg;
   localparam logic [0:0] ST_IDLE = `RAS_IDLE;
   localparam logic [0:0] ST_RET  = `RAS_RET;

   // A flag raised this cycle wins over a same-cycle clear.
   function automatic logic sticky_next(input logic cur, input logic clr, input logic set);
      return (cur & ~clr) | set;
   endfunction
endpackage

// File: rtl/lr_ras_mem.sv
// Return-address storage: synchronous write, combinational read, no reset.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef RAS_DEPTH
`define RAS_DEPTH 8
`endif
`ifndef RAS_PTR_W
`define RAS_PTR_W 3
`endif
module lr_ras_mem #(
   parameter int DEPTH = `RAS_DEPTH,
   parameter int PTR_W = `RAS_PTR_W
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [PTR_W-1:0]    i_waddr,
   input  logic [`DATA_W-1:0] i_wdata,
   input  logic [PTR_W-1:0]    i_raddr,
   output logic [`DATA_W-1:0] o_rdata
);
   logic [`DATA_W-1:0] r_mem [DEPTH];

   // Single write port.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/lr_ras.sv
// Return-address stack between link-register control and fetch; pops are
// presented to fetch as a registered valid/ready return-target redirect.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef RAS_DEPTH
`define RAS_DEPTH 8
`endif
`ifndef RAS_PTR_W
`define RAS_PTR_W 3
`endif
module lr_ras
   import lr_ras_pkg::*;
#(
   parameter int DEPTH = `RAS_DEPTH,
   parameter int PTR_W = `RAS_PTR_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [`DATA_W-1:0] set_lr,
   input  logic                lr_seten,
   input  logic                lr_recoven,
   input  logic                flush,
   input  logic                clr_err,
   output logic [`DATA_W-1:0] ret_pc,
   output logic                ret_valid,
   input  logic                ret_ready,
   output logic [PTR_W:0]      cnt,
   output logic                empty,
   output logic                full,
   output logic                ovf,
   output logic                udf,
   output logic                seq_err
);
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0]    r_tp;
   logic [PTR_W:0]      r_cnt;
   logic [0:0]          r_state;
   logic [`DATA_W-1:0] r_ret_pc;
   logic                r_ovf, r_udf, r_seq_err;

   logic                w_push, w_pop_req, w_can_pop, w_pop_ok;
   logic                w_empty, w_full;
   logic                w_udf_set, w_ovf_set, w_seq_set;
   logic [PTR_W-1:0]    w_tp_m1, w_waddr, w_tp_nxt;
   logic [PTR_W:0]      w_cnt_nxt;
   logic [`DATA_W-1:0] w_rdata;

   assign w_empty   = (r_cnt == {(PTR_W+1){1'b0}});
   assign w_full    = (r_cnt == CNT_MAX);
   assign w_push    = lr_seten & ~flush;
   assign w_pop_req = lr_recoven & ~flush;
   // A pop may only start when no return is pending or the pending one leaves now.
   assign w_can_pop = (r_state == ST_IDLE) | ret_ready;
   assign w_pop_ok  = w_pop_req & w_can_pop & ~w_empty;
   assign w_udf_set = w_pop_req & w_can_pop & w_empty;
   assign w_seq_set = w_pop_req & ~w_can_pop;
   assign w_ovf_set = w_push & ~w_pop_ok & w_full;
   assign w_tp_m1   = r_tp - PTR_ONE;
   // Push+pop replaces the top in place.
   assign w_waddr   = w_pop_ok ? w_tp_m1 : r_tp;

   lr_ras_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (w_waddr),
      .i_wdata (set_lr),
      .i_raddr (w_tp_m1),
      .o_rdata (w_rdata)
   );

   // Next top pointer and occupancy.
   always_comb begin
      w_tp_nxt  = r_tp;
      w_cnt_nxt = r_cnt;
      if (flush) begin
         w_tp_nxt  = {PTR_W{1'b0}};
         w_cnt_nxt = {(PTR_W+1){1'b0}};
      end else if (w_push && w_pop_ok) begin
         w_tp_nxt  = r_tp;
         w_cnt_nxt = r_cnt;
      end else if (w_push) begin
         w_tp_nxt  = r_tp + PTR_ONE;
         w_cnt_nxt = w_full ? r_cnt : (r_cnt + CNT_ONE);
      end else if (w_pop_ok) begin
         w_tp_nxt  = w_tp_m1;
         w_cnt_nxt = r_cnt - CNT_ONE;
      end else begin
         w_tp_nxt  = r_tp;
         w_cnt_nxt = r_cnt;
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tp  <= {PTR_W{1'b0}};
         r_cnt <= {(PTR_W+1){1'b0}};
      end else begin
         r_tp  <= w_tp_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   // Return handshake FSM; a completing handshake may chain straight into the next pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_ret_pc <= {`DATA_W{1'b0}};
      end else if (flush) begin
         r_state  <= ST_IDLE;
      end else if (w_pop_ok) begin
         r_state  <= ST_RET;
         r_ret_pc <= w_rdata;
      end else if ((r_state == ST_RET) && ret_ready) begin
         r_state  <= ST_IDLE;
      end
   end

   // Sticky error flags, cleared only by reset or clr_err.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         r_seq_err <= 1'b0;
      end else begin
         r_ovf     <= sticky_next(r_ovf, clr_err, w_ovf_set);
         r_udf     <= sticky_next(r_udf, clr_err, w_udf_set);
         r_seq_err <= sticky_next(r_seq_err, clr_err, w_seq_set);
      end
   end

   assign ret_pc    = r_ret_pc;
   assign ret_valid = (r_state == ST_RET);
   assign cnt       = r_cnt;
   assign empty     = w_empty;
   assign full      = w_full;
   assign ovf       = r_ovf;
   assign udf       = r_udf;
   assign seq_err   = r_seq_err;
endmodule

// File: tb/tb_lr_ras.sv
// Scoreboard bench for lr_ras: a reference stack predicts each return target,
// which is compared when fetch accepts it.
`ifndef DATA_W
`define DATA_W 32
`endif
module tb_lr_ras;
   logic                clk = 1'b0;
   logic                reset_n;
   logic [`DATA_W-1:0] set_lr;
   logic                lr_seten, lr_recoven, flush, clr_err, ret_ready;
   logic [`DATA_W-1:0] ret_pc;
   logic                ret_valid, empty, full, ovf, udf, seq_err;
   logic [3:0]          cnt;

   int errors = 0;
   int checks = 0;
   logic [`DATA_W-1:0] sb  [$];
   logic [`DATA_W-1:0] stk [$];
   logic m_valid, m_ovf, m_udf, m_seq;

   lr_ras dut (
      .clk(clk), .reset_n(reset_n), .set_lr(set_lr), .lr_seten(lr_seten),
      .lr_recoven(lr_recoven), .flush(flush), .clr_err(clr_err),
      .ret_pc(ret_pc), .ret_valid(ret_valid), .ret_ready(ret_ready),
      .cnt(cnt), .empty(empty), .full(full), .ovf(ovf), .udf(udf), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Accepted returns are compared against the scoreboard.
   always @(negedge clk) begin
      if (reset_n && ret_valid && ret_ready) begin
         if (sb.size() == 0) chk("spurious_ret", 64'd1, 64'd0);
         else chk("ret_pc", ret_pc, sb.pop_front());
      end
   end

   task automatic check_state();
      chk("ret_valid", ret_valid, m_valid);
      chk("cnt", cnt, stk.size());
      chk("empty", empty, stk.size() == 0);
      chk("full", full, stk.size() == 8);
      chk("ovf", ovf, m_ovf);
      chk("udf", udf, m_udf);
      chk("seq_err", seq_err, m_seq);
   endtask

   task automatic cyc(input logic push, input logic [`DATA_W-1:0] d,
                      input logic pop, input logic rdy, input logic clr);
      logic can, pok;
      lr_seten = push; set_lr = d; lr_recoven = pop; ret_ready = rdy; clr_err = clr;
      can = !m_valid || rdy;
      pok = pop && can && (stk.size() > 0);
      m_ovf = m_ovf & ~clr;
      m_udf = m_udf & ~clr;
      m_seq = m_seq & ~clr;
      if (pop && !can) m_seq = 1'b1;
      if (pop && can && stk.size() == 0) m_udf = 1'b1;
      if (pok) begin
         sb.push_back(stk[stk.size()-1]);
         if (push) stk[stk.size()-1] = d;
         else void'(stk.pop_back());
      end else if (push) begin
         if (stk.size() == 8) begin
            m_ovf = 1'b1;
            void'(stk.pop_front());
         end
         stk.push_back(d);
      end
      if (pok) m_valid = 1'b1;
      else if (rdy) m_valid = 1'b0;
      @(posedge clk); #1;
      check_state();
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, '0, 1'b0, rdy, 1'b0);
   endtask

   task automatic do_flush();
      lr_seten = 1'b1; set_lr = 32'hDEAD; lr_recoven = 1'b1; ret_ready = 1'b0; clr_err = 1'b0;
      flush = 1'b1;
      stk.delete(); sb.delete(); m_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      check_state();
   endtask

   task automatic do_reset();
      lr_seten = 1'b0; lr_recoven = 1'b0; ret_ready = 1'b0; clr_err = 1'b0;
      #2 reset_n = 1'b0;
      stk.delete(); sb.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_seq = 1'b0;
      #1;
      check_state();
      chk("rst_ret_pc", ret_pc, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 1'b0; set_lr = '0; lr_seten = 1'b0; lr_recoven = 1'b0;
      flush = 1'b0; clr_err = 1'b0; ret_ready = 1'b0;
      m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_seq = 1'b0;
      #12;
      check_state();
      chk("rst_ret_pc", ret_pc, 64'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // LIFO order with one-cycle latency
      cyc(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'h30, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // underflow then clear
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

      // overflow wraps the oldest entry
      for (int i = 1; i <= 9; i++) cyc(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

      // simultaneous push and pop replace the top
      cyc(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // pop while a return is stalled
      cyc(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("stall_ret_pc", ret_pc, 64'h66);
      idle(1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
      idle(1'b1);

      // flush keeps sticky flags
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      do_flush();
      idle(1'b1);

      // asynchronous reset while a return is pending
      cyc(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'h88, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      do_reset();
      check_state();
      cyc(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      chk("sb_drained", sb.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
